// File: rtl/console_uart_tx.sv
// Console byte sink: a small FIFO feeding an 8N1 UART transmitter.
// Bytes written by the core are queued and shifted out LSB first with no gap between frames.
module console_uart_tx #(
    parameter int XLEN         = 32,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          console_we,
    input  logic [XLEN-1:0]               console_wdata,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [15:0]     baud_r, baud_s;
    logic [2:0]      bit_r, bit_s;
    logic [2:0]      bit_inc_s;
    logic [7:0]      shift_r, shift_s;
    logic            tx_r, tx_s;
    logic [PW-1:0]   rd_ptr_r, wr_ptr_r;
    logic [LW-1:0]   level_r, level_s;
    logic            overflow_r, overflow_s;
    logic            busy_r, busy_s;
    logic            full_r, full_s;
    logic            pop_s, push_s, baud_end_s;
    logic [7:0]      mem_r [FIFO_DEPTH];

    // Upper write-data bits carry no console information.
    logic            unused_wdata_s;
    assign unused_wdata_s = ^console_wdata[XLEN-1:8];

    // Next-state, next-output and FIFO bookkeeping for the transmitter.
    always_comb begin
        state_s    = state_r;
        baud_s     = baud_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        tx_s       = tx_r;
        pop_s      = 1'b0;
        baud_end_s = (baud_r == BAUD_LAST);
        bit_inc_s  = bit_r + 3'd1;

        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                baud_s = 16'd0;
                bit_s  = 3'd0;
                if (level_r != {LW{1'b0}}) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    state_s = ST_START;
                    tx_s    = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_s  = 16'd0;
                    bit_s   = 3'd0;
                    state_s = ST_DATA;
                    tx_s    = shift_r[0];
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_s = bit_inc_s;
                        tx_s  = shift_r[bit_inc_s];
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_s = 16'd0;
                    bit_s  = 3'd0;
                    // Chain straight into the next start bit so frames stay gap-free.
                    if (level_r != {LW{1'b0}}) begin
                        pop_s   = 1'b1;
                        shift_s = mem_r[rd_ptr_r];
                        state_s = ST_START;
                        tx_s    = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                        tx_s    = 1'b1;
                    end
                end else begin
                    baud_s = baud_r + 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                baud_s  = 16'd0;
                bit_s   = 3'd0;
                tx_s    = 1'b1;
            end
        endcase

        push_s     = console_we && ((level_r != DEPTH_L) || pop_s);
        overflow_s = overflow_r || (console_we && !push_s);

        case ({push_s, pop_s})
            2'b10:   level_s = level_r + LVL_ONE;
            2'b01:   level_s = level_r - LVL_ONE;
            default: level_s = level_r;
        endcase

        full_s = (level_s == DEPTH_L);
        busy_s = (state_s != ST_IDLE) || (level_s != {LW{1'b0}});
    end

    // State, counters, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            baud_r     <= 16'd0;
            bit_r      <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            level_r    <= {LW{1'b0}};
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_r     <= baud_s;
            bit_r      <= bit_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            rd_ptr_r   <= pop_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
            wr_ptr_r   <= push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
            level_r    <= level_s;
            overflow_r <= overflow_s;
            busy_r     <= busy_s;
            full_r     <= full_s;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem_r[wr_ptr_r] <= console_wdata[7:0];
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign full     = full_r;
    assign level    = level_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_console_uart_tx.sv
// Randomized and directed bench for console_uart_tx: frame-level reference model plus
// a UART receiver monitor that pops expected bytes from a scoreboard queue.
module tb_console_uart_tx;

    localparam int XW    = 32;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          console_we = 1'b0;
    logic [XW-1:0] console_wdata = '0;
    logic          tx, busy, full, overflow;
    logic [2:0]    level;

    console_uart_tx #(.XLEN(XW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .console_we(console_we), .console_wdata(console_wdata),
        .tx(tx), .busy(busy), .full(full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int rst_cnt = 0;

    // Reference model: buffered bytes, the frame on the wire and its age in cycles.
    logic [7:0] m_q[$];
    logic [7:0] sb_q[$];
    bit         m_inflight = 1'b0;
    int         m_age = 0;
    logic [7:0] m_byte = 8'd0;
    bit         m_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit we, input logic [7:0] d);
        int  lvl;
        bit  pop;
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_inflight = 1'b0;
            m_age = 0;
            m_ovf = 1'b0;
            rst_cnt++;
        end else begin
            lvl = m_q.size();
            pop = 1'b0;
            if (m_inflight) m_age++;
            if (m_inflight && m_age == FRAME) m_inflight = 1'b0;
            if (!m_inflight && lvl > 0) begin
                m_byte = m_q.pop_front();
                m_inflight = 1'b1;
                m_age = 0;
                pop = 1'b1;
            end
            if (we) begin
                if (lvl < DEPTH || pop) begin
                    m_q.push_back(d);
                    sb_q.push_back(d);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    function automatic logic exp_tx();
        int slot;
        if (!m_inflight) return 1'b1;
        slot = m_age / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot-1];
    endfunction

    task automatic check_outputs();
        chk("tx", {31'd0, tx}, {31'd0, exp_tx()});
        chk("level", {29'd0, level}, 32'(m_q.size()));
        chk("full", {31'd0, full}, {31'd0, m_q.size() == DEPTH});
        chk("busy", {31'd0, busy}, {31'd0, m_inflight || m_q.size() != 0});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic step(input bit rst_n, input bit we, input logic [XW-1:0] d);
        reset = rst_n;
        console_we = we;
        console_wdata = d;
        model_edge(rst_n, we, d[7:0]);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_inflight || m_q.size() != 0) && guard < 2000) begin
            step(1'b1, 1'b0, '0);
            guard++;
        end
        chk("drain_timeout", 32'(guard >= 2000), 32'd0);
        idle(3);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // UART receiver: samples mid-bit and compares each decoded byte with the scoreboard.
    initial begin : monitor
        bit         active = 1'b0;
        int         ph = 0;
        int         last_rst = 0;
        logic [7:0] b = 8'd0;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_cnt != last_rst) begin
                last_rst = rst_cnt;
                active = 1'b0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    ph = 0;
                end
            end else begin
                ph++;
                if (ph >= CPB + 2 && ph < 9 * CPB && ((ph - 2) % CPB) == 0)
                    b[(ph - 2) / CPB - 1] = tx;
                if (ph == 9 * CPB + 2) begin
                    chk("stop_bit", {31'd0, tx}, 32'd1);
                    if (sb_q.size() == 0) begin
                        chk("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rx_byte", {24'd0, b}, {24'd0, e});
                    end
                end
                if (ph == FRAME - 1) active = 1'b0;
            end
        end
    end

    initial begin : stimulus
        int guard;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_00AA);
        // Single 0x41 one cycle after reset release.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0041);
        drain();
        // Only the low byte of the write data is transmitted.
        step(1'b1, 1'b1, 32'hDEAD_BE42);
        drain();
        // Contiguous burst.
        step(1'b1, 1'b1, 32'h55);
        step(1'b1, 1'b1, 32'hAA);
        step(1'b1, 1'b1, 32'h0F);
        drain();
        // Overfill from IDLE: sixth byte is dropped, overflow sticks.
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b1, 32'(i));
        drain();
        chk("overflow_sticky", {31'd0, overflow}, 32'd1);
        // Write landing on the stop-to-start pop while full is accepted.
        step(1'b0, 1'b0, '0);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 32'h10 + 32'(i));
        chk("full_before_pop", {31'd0, full}, 32'd1);
        guard = 0;
        while (!(m_inflight && m_age == FRAME - 1) && guard < 200) begin
            step(1'b1, 1'b0, '0);
            guard++;
        end
        chk("pop_wait_timeout", 32'(guard >= 200), 32'd0);
        step(1'b1, 1'b1, 32'h77);
        chk("level_at_pop", {29'd0, level}, 32'd4);
        chk("no_overflow_at_pop", {31'd0, overflow}, 32'd0);
        drain();
        // Reset during data bit 3 of 0x3C with two bytes buffered.
        step(1'b1, 1'b1, 32'h3C);
        step(1'b1, 1'b1, 32'h11);
        step(1'b1, 1'b1, 32'h22);
        guard = 0;
        while (!(m_inflight && m_age == 4 * CPB + 1) && guard < 100) begin
            step(1'b1, 1'b0, '0);
            guard++;
        end
        step(1'b0, 1'b0, '0);
        chk("abort_tx", {31'd0, tx}, 32'd1);
        chk("abort_level", {29'd0, level}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        idle(2 * FRAME);
        // Randomized traffic with rare resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                step(1'b0, 1'b0, '0);
            else
                step(1'b1, $urandom_range(0, 5) == 0, $urandom);
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
